// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory arbiter: FSM states, grant IDs and the
// nominal request-to-done latencies of the single-bank controller path.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE0 = 3'd1,
    ST_ISSUE1 = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] GNT_VGA = 2'd0;
  localparam logic [1:0] GNT_A   = 2'd1;
  localparam logic [1:0] GNT_B   = 2'd2;

  localparam int ISSUE_CYCLES = 2;

  localparam int LAT_READ    = 34;
  localparam int LAT_WRITE   = 7;
  localparam int LAT_TIMEOUT = 66;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selector: VGA first unless it was served last while a
// client waits; A and B alternate through the round-robin bit rr.
import mem_arb_pkg::*;

module mem_arb_pick (
  input  logic       vga_req,
  input  logic       a_req,
  input  logic       b_req,
  input  logic       last_vga,
  input  logic       rr,
  output logic [1:0] gnt,
  output logic       valid
);

  logic client_req;

  assign client_req = a_req | b_req;
  assign valid      = vga_req | client_req;

  always_comb begin
    gnt = GNT_VGA;
    if (vga_req && !(last_vga && client_req)) begin
      gnt = GNT_VGA;
    end else if (a_req && b_req) begin
      // rr = 1 means A was served last, so B takes the tie.
      gnt = rr ? GNT_B : GNT_A;
    end else if (a_req) begin
      gnt = GNT_A;
    end else if (b_req) begin
      gnt = GNT_B;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Three-requester front end for the single-bank memory controller: grants one
// transaction at a time, holds strobes two cycles and guards WAIT with a watchdog.
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int ROW_W  = 14,
  parameter int TMO_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_done,
  output logic [ROW_W-1:0]  vga_rdata,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [1:0]        a_wdata,
  output logic              a_done,
  output logic [ROW_W-1:0]  a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [1:0]        b_wdata,
  output logic              b_done,
  output logic [ROW_W-1:0]  b_rdata,
  output logic              err,
  output logic              rden_vga,
  output logic              rden_ctl,
  output logic              wren_ctl,
  output logic [ADDR_W-1:0] addr_vga,
  output logic [ADDR_W-1:0] addr_ctl,
  output logic [1:0]        q_in,
  input  logic              ready_vga,
  input  logic              ready_ctl,
  input  logic [ROW_W-1:0]  data_c_m
);

  state_t             state_reg, state_next;
  logic [1:0]         gnt_reg, gnt_next;
  logic               we_reg, we_next;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [1:0]         wdata_reg, wdata_next;
  logic [ROW_W-1:0]   row_reg, row_next;
  logic               tmo_reg, tmo_next;
  logic [TMO_W-1:0]   wdog_reg, wdog_next;
  logic               rr_reg, rr_next;
  logic               last_vga_reg, last_vga_next;

  logic [1:0]         pick_gnt;
  logic               pick_valid;
  logic               ready_match;
  logic [TMO_W-1:0]   wdog_inc;

  mem_arb_pick u_pick (
    .vga_req  (vga_req),
    .a_req    (a_req),
    .b_req    (b_req),
    .last_vga (last_vga_reg),
    .rr       (rr_reg),
    .gnt      (pick_gnt),
    .valid    (pick_valid)
  );

  assign ready_match = (gnt_reg == GNT_VGA) ? ready_vga : ready_ctl;
  assign wdog_inc    = wdog_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      gnt_reg      <= GNT_VGA;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      row_reg      <= '0;
      tmo_reg      <= 1'b0;
      wdog_reg     <= '0;
      rr_reg       <= 1'b0;
      last_vga_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      row_reg      <= row_next;
      tmo_reg      <= tmo_next;
      wdog_reg     <= wdog_next;
      rr_reg       <= rr_next;
      last_vga_reg <= last_vga_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    we_next       = we_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    row_next      = row_reg;
    tmo_next      = tmo_reg;
    wdog_next     = wdog_reg;
    rr_next       = rr_reg;
    last_vga_next = last_vga_reg;
    rden_vga      = 1'b0;
    rden_ctl      = 1'b0;
    wren_ctl      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_next      = pick_gnt;
          last_vga_next = (pick_gnt == GNT_VGA);
          row_next      = '0;
          tmo_next      = 1'b0;
          wdog_next     = '0;
          state_next    = ST_ISSUE0;
          case (pick_gnt)
            GNT_A: begin
              we_next    = a_we;
              addr_next  = a_addr;
              wdata_next = a_wdata;
              rr_next    = 1'b1;
            end
            GNT_B: begin
              we_next    = b_we;
              addr_next  = b_addr;
              wdata_next = b_wdata;
              rr_next    = 1'b0;
            end
            default: begin
              we_next    = 1'b0;
              addr_next  = vga_addr;
              wdata_next = '0;
            end
          endcase
        end
      end
      // The controller re-samples its strobe one cycle after leaving idle,
      // so the strobe spans both issue states.
      ST_ISSUE0, ST_ISSUE1: begin
        if (gnt_reg == GNT_VGA) begin
          rden_vga = 1'b1;
        end else if (we_reg) begin
          wren_ctl = 1'b1;
        end else begin
          rden_ctl = 1'b1;
        end
        state_next = (state_reg == ST_ISSUE0) ? ST_ISSUE1 : ST_WAIT;
      end
      ST_WAIT: begin
        wdog_next = wdog_inc;
        if (ready_match) begin
          if (!we_reg) begin
            row_next = data_c_m;
          end
          state_next = ST_DONE;
        end else if (wdog_inc == '1) begin
          tmo_next   = 1'b1;
          row_next   = '0;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    addr_vga = '0;
    addr_ctl = '0;
    q_in     = '0;
    if (state_reg != ST_IDLE) begin
      q_in = wdata_reg;
      if (gnt_reg == GNT_VGA) begin
        addr_vga = addr_reg;
      end else begin
        addr_ctl = addr_reg;
      end
    end
  end

  logic [2:0]       done_vec;
  logic [ROW_W-1:0] rdata_vec [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ret
      assign done_vec[gi]  = (state_reg == ST_DONE) && (gnt_reg == 2'(gi));
      assign rdata_vec[gi] = done_vec[gi] ? row_reg : '0;
    end
  endgenerate

  assign vga_done  = done_vec[GNT_VGA];
  assign a_done    = done_vec[GNT_A];
  assign b_done    = done_vec[GNT_B];
  assign vga_rdata = rdata_vec[GNT_VGA];
  assign a_rdata   = rdata_vec[GNT_A];
  assign b_rdata   = rdata_vec[GNT_B];
  assign err       = (state_reg == ST_DONE) && tmo_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural controller model
// whose ready timing is adjustable (normal, hung, spurious wrong-line ready).
module tb_mem_arbiter;

  localparam int ADDR_W = 6;
  localparam int ROW_W  = 14;

  logic              clk = 1'b0;
  logic              reset;
  logic              vga_req, a_req, b_req, a_we, b_we;
  logic [ADDR_W-1:0] vga_addr, a_addr, b_addr;
  logic [1:0]        a_wdata, b_wdata;
  logic              vga_done, a_done, b_done, err;
  logic [ROW_W-1:0]  vga_rdata, a_rdata, b_rdata;
  logic              rden_vga, rden_ctl, wren_ctl;
  logic [ADDR_W-1:0] addr_vga, addr_ctl;
  logic [1:0]        q_in;
  logic              ready_vga, ready_ctl;
  logic [ROW_W-1:0]  data_c_m;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_done(vga_done), .vga_rdata(vga_rdata),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_done(b_done), .b_rdata(b_rdata),
    .err(err), .rden_vga(rden_vga), .rden_ctl(rden_ctl), .wren_ctl(wren_ctl),
    .addr_vga(addr_vga), .addr_ctl(addr_ctl), .q_in(q_in),
    .ready_vga(ready_vga), .ready_ctl(ready_ctl), .data_c_m(data_c_m)
  );

  // Controller model: ready arrives 5 (write) or 32 (read) cycles after the
  // first strobe cycle, i.e. done at 7 / 34 cycles after the request.
  logic             hang, spur;
  logic [ROW_W-1:0] row_data;
  logic             mdl_busy, mdl_vga, mdl_we, mdl_hit;
  int               mdl_cnt;

  always @(posedge clk) begin
    if (reset || vga_done || a_done || b_done) begin
      mdl_busy <= 1'b0;
      mdl_cnt  <= 0;
    end else if (!mdl_busy && (rden_vga || rden_ctl || wren_ctl)) begin
      mdl_busy <= 1'b1;
      mdl_cnt  <= 1;
      mdl_vga  <= rden_vga;
      mdl_we   <= wren_ctl;
    end else if (mdl_busy) begin
      mdl_cnt <= mdl_cnt + 1;
    end
  end

  assign mdl_hit   = mdl_busy && !hang && (mdl_cnt == (mdl_we ? 5 : 32));
  assign ready_vga = mdl_hit && mdl_vga;
  assign ready_ctl = (mdl_hit && !mdl_vga) || (spur && mdl_busy && mdl_cnt == 10);
  assign data_c_m  = row_data;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observations of the most recent transaction.
  int                done_cyc, n_rv, n_rc, n_wc;
  logic [2:0]        done_vec;
  logic              err_seen, hold_bad;
  logic [ROW_W-1:0]  vr, ar, br;
  logic [ADDR_W-1:0] av0, ac0;
  logic [1:0]        q0;

  task automatic run_txn(input int limit);
    done_cyc = 0; done_vec = 3'b000; err_seen = 1'b0; hold_bad = 1'b0;
    n_rv = 0; n_rc = 0; n_wc = 0;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk); #1;
      n_rv += int'(rden_vga);
      n_rc += int'(rden_ctl);
      n_wc += int'(wren_ctl);
      if (c == 1) begin
        av0 = addr_vga; ac0 = addr_ctl; q0 = q_in;
      end else if (addr_vga !== av0 || addr_ctl !== ac0 || q_in !== q0) begin
        hold_bad = 1'b1;
      end
      if (vga_done || a_done || b_done) begin
        done_cyc = c;
        done_vec = {vga_done, a_done, b_done};
        err_seen = err;
        vr = vga_rdata; ar = a_rdata; br = b_rdata;
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  logic [2:0] exp_order [6];

  initial begin
    reset = 1'b1;
    vga_req = 0; a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    vga_addr = '0; a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    hang = 0; spur = 0; row_data = '0;
    exp_order[0] = 3'b100; exp_order[1] = 3'b010; exp_order[2] = 3'b100;
    exp_order[3] = 3'b001; exp_order[4] = 3'b100; exp_order[5] = 3'b010;

    idle(3);
    chk("reset_strobes", {29'd0, rden_vga, rden_ctl, wren_ctl}, 32'd0);
    chk("reset_done", {28'd0, vga_done, a_done, b_done, err}, 32'd0);
    chk("reset_addr_q", {18'd0, addr_vga, addr_ctl, q_in}, 32'd0);
    reset = 1'b0;

    // Contention: all three hold requests; clients write for speed.
    row_data = 14'h0155; vga_addr = 6'd1;
    a_we = 1; a_addr = 6'd2; a_wdata = 2'b01;
    b_we = 1; b_addr = 6'd3; b_wdata = 2'b11;
    vga_req = 1; a_req = 1; b_req = 1;
    for (int t = 0; t < 6; t++) begin
      run_txn(200);
      if (t == 5) begin
        vga_req = 0; a_req = 0; b_req = 0;
      end
      $display("contention txn %0d: done={vga,a,b}=%b after %0d cycles", t, done_vec, done_cyc);
      chk($sformatf("contention_order_%0d", t), {29'd0, done_vec}, {29'd0, exp_order[t]});
    end
    idle(2);

    // VGA read.
    vga_addr = 6'd14; row_data = 14'h2A5C; vga_req = 1;
    run_txn(100);
    vga_req = 0;
    $display("vga read: done=%b cyc=%0d rdata=%h", done_vec, done_cyc, vr);
    chk("vga_done_who", {29'd0, done_vec}, 32'b100);
    chk("vga_latency", done_cyc, 34);
    chk("vga_rdata", {18'd0, vr}, 32'h2A5C);
    chk("vga_rden_cycles", n_rv, 2);
    chk("vga_ctl_strobes", n_rc + n_wc, 0);
    chk("vga_addr", {26'd0, av0}, 32'd14);
    chk("vga_addr_hold", {31'd0, hold_bad}, 32'd0);
    chk("vga_err", {31'd0, err_seen}, 32'd0);
    idle(2);

    // Client A write.
    a_we = 1; a_addr = 6'd5; a_wdata = 2'b10; a_req = 1;
    run_txn(100);
    a_req = 0;
    $display("a write: done=%b cyc=%0d err=%b", done_vec, done_cyc, err_seen);
    chk("a_done_who", {29'd0, done_vec}, 32'b010);
    chk("a_write_latency", done_cyc, 7);
    chk("a_wren_cycles", n_wc, 2);
    chk("a_other_strobes", n_rv + n_rc, 0);
    chk("a_addr_ctl", {26'd0, ac0}, 32'd5);
    chk("a_q_in", {30'd0, q0}, 32'd2);
    chk("a_hold", {31'd0, hold_bad}, 32'd0);
    chk("a_err", {31'd0, err_seen}, 32'd0);
    chk("a_rdata_write", {18'd0, ar}, 32'd0);
    idle(2);

    // Spurious ready_ctl during a VGA read must be ignored.
    vga_addr = 6'd33; row_data = 14'h1234; spur = 1; vga_req = 1;
    run_txn(100);
    vga_req = 0; spur = 0;
    $display("wrong-ready: done=%b cyc=%0d rdata=%h", done_vec, done_cyc, vr);
    chk("wrong_ready_who", {29'd0, done_vec}, 32'b100);
    chk("wrong_ready_latency", done_cyc, 34);
    chk("wrong_ready_rdata", {18'd0, vr}, 32'h1234);
    idle(2);

    // Reset while A read sits in WAIT; rr must return to favouring A.
    a_we = 0; a_addr = 6'd9; a_req = 1;
    idle(10);
    chk("pre_reset_in_wait", {25'd0, rden_ctl, addr_ctl}, {25'd0, 1'b0, 6'd9});
    reset = 1;
    @(posedge clk); #1;
    $display("reset in wait: strobes=%b%b%b dones=%b%b%b", rden_vga, rden_ctl, wren_ctl,
             vga_done, a_done, b_done);
    chk("midreset_strobes_done", {26'd0, rden_vga, rden_ctl, wren_ctl, vga_done, a_done, b_done}, 32'd0);
    chk("midreset_addr", {20'd0, addr_vga, addr_ctl}, 32'd0);
    reset = 0;
    a_we = 1; a_wdata = 2'b01; b_req = 1; b_we = 1; b_addr = 6'd7;
    run_txn(100);
    a_req = 0;
    $display("after reset: first done=%b cyc=%0d", done_vec, done_cyc);
    chk("post_reset_first", {29'd0, done_vec}, 32'b010);
    chk("post_reset_latency", done_cyc, 7);
    run_txn(100);
    b_req = 0;
    $display("after reset: second done=%b", done_vec);
    chk("post_reset_second", {29'd0, done_vec}, 32'b001);
    idle(2);

    // Watchdog: controller never answers the B read.
    hang = 1; row_data = 14'h3FFF; b_we = 0; b_addr = 6'd40; b_req = 1;
    run_txn(200);
    b_req = 0; hang = 0;
    $display("timeout: done=%b cyc=%0d err=%b rdata=%h", done_vec, done_cyc, err_seen, br);
    chk("tmo_who", {29'd0, done_vec}, 32'b001);
    chk("tmo_latency", done_cyc, 66);
    chk("tmo_err", {31'd0, err_seen}, 32'd1);
    chk("tmo_rdata", {18'd0, br}, 32'd0);
    chk("tmo_rden_cycles", n_rc, 2);
    idle(2);

    a_we = 1; a_addr = 6'd3; a_wdata = 2'b11; a_req = 1;
    run_txn(100);
    a_req = 0;
    $display("post-timeout write: done=%b cyc=%0d err=%b", done_vec, done_cyc, err_seen);
    chk("post_tmo_who", {29'd0, done_vec}, 32'b010);
    chk("post_tmo_latency", done_cyc, 7);
    chk("post_tmo_err", {31'd0, err_seen}, 32'd0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 time units");
    $fatal(1, "bench time limit exceeded");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between three requesters and the single-bank memory controller (mem_control).
- Requesters: the VGA scanner (read-only) and two control clients, A and B (read/write).
- Grants one request at a time and drives the controller's strobe and address inputs. Captures the 14-bit row result or write completion, then returns a one-cycle done pulse to the winner.
- VGA has priority, with an anti-starvation rule; A and B share access round-robin. A watchdog terminates hung transactions.

Parameters:
- ADDR_W, 6, memory address width.
- ROW_W, 14, read row width (7 cells x 2 bits).
- TMO_W, 6, watchdog counter width; timeout fires at 2^TMO_W-1 = 63 cycles in WAIT.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- vga_req  in  1  VGA row-read request; held until vga_done.
- vga_addr  in  ADDR_W  VGA row base address.
- vga_done  out  1  one-cycle pulse; vga_rdata valid this cycle.
- vga_rdata  out  ROW_W  registered row data.
- a_req / b_req  in  1  client request; held until that client's done.
- a_we / b_we  in  1  1 = write one cell, 0 = read row.
- a_addr / b_addr  in  ADDR_W  client address.
- a_wdata / b_wdata  in  2  write cell value.
- a_done / b_done  out  1  one-cycle completion pulse.
- a_rdata / b_rdata  out  ROW_W  registered read data (undefined after writes; driven 0).
- err  out  1  one-cycle pulse coincident with a done that ended by timeout.
- rden_vga, rden_ctl, wren_ctl  out  1  strobes to the controller.
- addr_vga, addr_ctl  out  ADDR_W  controller addresses.
- q_in  out  2  controller write data.
- ready_vga, ready_ctl  in  1  controller completion.
- data_c_m  in  ROW_W  controller row data.

Behaviour:
- States: IDLE, ISSUE0, ISSUE1, WAIT, DONE.
- IDLE:
  - Evaluate requests. If any are pending, latch grant ID, we, addr and wdata into registers, then go to ISSUE0.
- Priority order:
  - VGA wins, unless the previous grant was VGA and a_req|b_req is pending; then a client wins.
  - Between A and B: round-robin pointer rr; the client not served last wins a tie.
  - rr updates only when a client is granted.
- ISSUE0 and ISSUE1:
  - Assert exactly one strobe: rden_vga for VGA, wren_ctl for a client write, rden_ctl for a client read.
  - Strobes must be held 2 cycles because the controller re-samples the strobe one cycle after leaving its idle state.
  - Both strobes go low from WAIT onward.
- Address and data hold:
  - addr_vga/addr_ctl and q_in are driven from the latched registers from ISSUE0 through DONE, and are 0 otherwise.
- WAIT:
  - The watchdog counter increments each cycle.
  - On the expected ready (ready_vga for a VGA grant, ready_ctl for a client grant): capture data_c_m into the latched row register (reads), go to DONE.
  - A ready on the non-matching line is ignored.
  - On counter reaching 63: set the timeout flag, row register <= 0, go to DONE.
- DONE:
  - Pulse the granted requester's done for 1 cycle with its rdata = row register; err = timeout flag.
  - Return to IDLE.
  - A request still high in IDLE is treated as a new request; requesters must drop req the cycle after done.
- Nominal latency, req to done:
  - Read: 2 issue + ~31 controller cycles + 1 = 34 cycles.
  - Write: 2 + 4 + 1 = 7 cycles.
- Back-to-back: at least one IDLE cycle separates transactions.
- Reset values:
  - All outputs 0; state IDLE; rr = 0 (A favoured); last-was-VGA = 0; counters and registers 0.
- Reset mid-transaction:
  - Abort with no done pulse and strobes dropped the same cycle.
  - The controller is reset from the same source and is not relied on to finish.
- Requester drops req before done: the transaction still completes and done is still pulsed.

Decomposition:
- Package mem_arb_pkg:
  - State encodings.
  - Grant IDs GNT_VGA=0, GNT_A=1, GNT_B=2.
  - ISSUE_CYCLES=2.
  - Nominal latency constants for the bench.
- One sub-module, mem_arb_pick: combinational priority/round-robin selector.
  - Inputs: vga_req, a_req, b_req, last_vga, rr.
  - Outputs: grant ID and valid.

Test Plan:
- VGA read: vga_addr=14, controller model returns 14'h2A5C -> rden_vga high exactly 2 cycles, addr_vga=14 held, vga_done at cycle 34 with vga_rdata=14'h2A5C.
- A write: a_we=1, a_addr=5, a_wdata=2'b10 -> wren_ctl 2 cycles, q_in=2'b10, addr_ctl=5, a_done at cycle 7, err=0.
- Contention: vga, a and b all request continuously -> grant order VGA, A, VGA, B, VGA, A; no requester waits more than 2 transactions.
- Timeout: controller model never asserts ready_ctl on a b read -> b_done and err pulse together 66 cycles after b_req, b_rdata=0, next request serviced normally.
- Wrong-ready: VGA grant with a spurious ready_ctl in WAIT -> ignored; completion only on ready_vga.
- Reset asserted in WAIT -> next cycle all strobes and done 0, state IDLE; after release, a pending a_req is granted before b_req.
